ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single SUBLEQ machine RAM between two requesters: the core control unit and a program loader/debug port.
- Selects one requester, holds the access for a fixed number of cycles, captures read data and returns a one-cycle ack.
- Sits between the requesters and the RAM. Replaces direct control-unit-to-RAM wiring when a loader is present.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- ACC_CYC, 1, cycles ram_ena is held per access; must be >= 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- res  in  1  reset, asynchronous, active-low
- c_req  in  1  core access request; held high until c_ack
- c_we  in  1  core write enable (1 = write, 0 = read)
- c_adr  in  ADDR_W  core address
- c_wdat  in  DATA_W  core write data
- c_ack  out  1  one-cycle pulse at completion of a core access
- c_rdat  out  DATA_W  core read data, registered
- l_req, l_we, l_adr, l_wdat, l_ack, l_rdat: loader equivalents of the c_* ports, same directions and widths
- l_lock  in  1  loader requests exclusive ownership of the RAM
- core_hold  out  1  tells the control unit to stall while the loader holds the lock
- ram_ena  out  1  RAM enable
- ram_we  out  1  RAM write strobe
- ram_adr  out  ADDR_W  RAM address
- ram_wdat  out  DATA_W  RAM write data
- ram_rdat  in  DATA_W  RAM read data, valid while ram_ena is high
- busy  out  1  high whenever state is not IDLE
- owner  out  1  0 = core, 1 = loader; valid while busy

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE, counter=0, last_grant=loader so the core wins the first tie.
  - All outputs 0, including c_rdat and l_rdat.
  - An in-flight access is dropped with no ack.
- Eligibility: core is eligible when c_req=1 and core_hold=0. Loader is eligible when l_req=1.
- core_hold: register of l_lock, so it changes one edge after l_lock.
- IDLE:
  - If exactly one requester is eligible, grant it. If both, grant the one not equal to last_grant.
  - On the grant edge: latch adr, wdat and we into internal registers; set owner; load counter=ACC_CYC-1; go to ACC.
- ACC:
  - ram_ena=1; ram_we=latched we; ram_adr and ram_wdat driven from the latched registers.
  - Requester inputs are ignored after the grant edge.
  - Counter decrements each cycle. When counter==0: on a read, capture ram_rdat into the owner's rdat register; then go to ACK.
  - ram_ena is high for exactly ACC_CYC cycles.
- ACK:
  - Owner's ack=1 for one cycle; last_grant=owner; return to IDLE.
  - ram_ena=0 and ram_we=0.
- Latency: req seen at edge E → ack high in the cycle after edge E+ACC_CYC. Back-to-back accesses occupy ACC_CYC+2 cycles each.
- Timing of the earliest next grant: IDLE is re-evaluated at the edge ending ACK. A requester still asserting req in its ack cycle is treated as a new request.
- Write access: the owner's rdat is unchanged. rdat holds its value until the next read by that requester completes.
- Requester drops req mid-access: the access still completes and ack still pulses.
- l_lock rises during a core access: that access completes. Afterwards the core is not granted until core_hold falls.
- l_lock falls: core_hold falls one edge later; the core becomes eligible again.
- The arbiter never grants both requesters in the same cycle. c_ack and l_ack are never high together.

Decomposition:
- Shared package subleq_pkg holds:
  - ADDR_W and DATA_W defaults
  - arbiter state encoding: ARB_IDLE=2'd0, ARB_ACC=2'd1, ARB_ACK=2'd2
  - owner encoding: OWN_CORE=1'b0, OWN_LDR=1'b1
- One sub-module: rr_pick2, a combinational 2-way round-robin picker. Inputs: eligible[1:0], last_grant. Output: winner plus a valid flag.
- FSM, counter and data registers stay in ram_arbiter.

Test Plan:
1. Reset then core read, ACC_CYC=1, c_adr=8'h10, RAM[8'h10]=8'h5A → ram_ena high 1 cycle with ram_adr=8'h10; c_ack pulses 2 cycles after the grant edge; c_rdat=8'h5A; l_ack stays 0.
2. Core and loader both request from IDLE straight after reset → core granted first, loader next. Repeated simultaneous requests alternate core/loader/core.
3. Loader write, ACC_CYC=3, l_adr=8'h20, l_wdat=8'hC3 → ram_ena and ram_we high for exactly 3 cycles with ram_wdat=8'hC3; then a core read of 8'h20 returns 8'hC3.
4. l_lock asserted during a core access; c_req held high → the current core ack still arrives; core_hold=1 on the next edge; loader accesses only until l_lock falls; core granted afterwards.
5. res pulled low mid-ACC (ACC_CYC=3, second cycle) → busy, ram_ena, c_rdat and l_rdat go to 0 immediately; no ack; after res=1, a new core request completes normally.
6. Core drops c_req one cycle after the grant → access still finishes; c_ack still pulses once; next IDLE sees no request and busy=0.

Source files
------------

// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ machine: bus width defaults,
// RAM arbiter state encoding and requester/owner encoding.
package subleq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ACC  = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_e;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// eligible[0] is the core, eligible[1] is the loader; on a tie the
// requester that did not win last time is chosen.
module rr_pick2
  import subleq_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  // Pick the single eligible requester, or alternate against last_grant on a tie.
  always_comb begin
    valid  = |eligible;
    winner = OWN_CORE;
    if (eligible == 2'b11) begin
      winner = ~last_grant;
    end else if (eligible[1]) begin
      winner = OWN_LDR;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the SUBLEQ RAM between the core control unit and the loader/debug
// port. One access at a time: grant, hold ram_ena for ACC_CYC cycles,
// capture read data into the owner's register, then pulse the owner's ack.
module ram_arbiter
  import subleq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_CYC = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_adr,
  input  logic [DATA_W-1:0] c_wdat,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdat,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_adr,
  input  logic [DATA_W-1:0] l_wdat,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdat,
  input  logic              l_lock,
  output logic              core_hold,
  output logic              ram_ena,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_wdat,
  input  logic [DATA_W-1:0] ram_rdat,
  output logic              busy,
  output logic              owner
);

  // The counter only ever holds ACC_CYC-1 down to 0.
  localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] c_rdat_q, c_rdat_d;
  logic [DATA_W-1:0] l_rdat_q, l_rdat_d;
  logic              core_hold_q, core_hold_d;

  logic [1:0]        eligible;
  logic              pick_winner;
  logic              pick_valid;

  // The core is locked out while the registered copy of l_lock is high.
  assign eligible = {l_req, c_req & ~core_hold_q};

  rr_pick2 u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // Next-state logic: grant in IDLE, count down in ACC, hand back in ACK.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    c_rdat_d     = c_rdat_q;
    l_rdat_d     = l_rdat_q;
    core_hold_d  = l_lock;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          cnt_d   = CNT_LOAD;
          state_d = ARB_ACC;
          if (pick_winner == OWN_LDR) begin
            we_d   = l_we;
            adr_d  = l_adr;
            wdat_d = l_wdat;
          end else begin
            we_d   = c_we;
            adr_d  = c_adr;
            wdat_d = c_wdat;
          end
        end
      end
      ARB_ACC: begin
        if (cnt_q == '0) begin
          state_d = ARB_ACK;
          if (!we_q) begin
            if (owner_q == OWN_LDR) begin
              l_rdat_d = ram_rdat;
            end else begin
              c_rdat_d = ram_rdat;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_ACK: begin
        last_grant_d = owner_q;
        state_d      = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and data registers; reset drops any in-flight access silently.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CORE;
      last_grant_q <= OWN_LDR;
      we_q         <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      c_rdat_q     <= '0;
      l_rdat_q     <= '0;
      core_hold_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      c_rdat_q     <= c_rdat_d;
      l_rdat_q     <= l_rdat_d;
      core_hold_q  <= core_hold_d;
    end
  end

  assign busy      = (state_q != ARB_IDLE);
  assign owner     = owner_q;
  assign core_hold = core_hold_q;
  assign c_rdat    = c_rdat_q;
  assign l_rdat    = l_rdat_q;
  assign c_ack     = (state_q == ARB_ACK) && (owner_q == OWN_CORE);
  assign l_ack     = (state_q == ARB_ACK) && (owner_q == OWN_LDR);
  assign ram_ena   = (state_q == ARB_ACC);
  assign ram_we    = (state_q == ARB_ACC) && we_q;
  assign ram_adr   = adr_q;
  assign ram_wdat  = wdat_q;

endmodule
